// File: rtl/mc_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : mc_host_driver
// Description : Host-side driver for the Monte Carlo pricing chip. Runs one
//               pricing job per accepted start:
//               - sends the mode code and the w, q, S, K parameters;
//               - captures the generated path stream into a local buffer;
//               - replays the buffer in pricing mode, rewinding to the start
//                 of the current path whenever the chip asks for a resend;
//               - returns the final price.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: WATCHDOG_EN
//   Defined   : a 13-bit idle counter aborts CAPTURE/PRICE after TIMEOUT
//               cycles without chip_valid and raises err.
//   Undefined : no counter, err tied low, the FSM waits indefinitely.
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   one-cycle job request, ignored while busy
//   w_i,q_i,
//   s_i,k_i      in  12   job parameters, latched on an accepted start
//   busy         out  1   job in progress
//   done         out  1   one-cycle pulse at end of job
//   price_o      out 12   price result
//   err          out  1   watchdog abort flag
//   chip_state   out  2   mode code: 0 idle, 1 param, 2 sobol, 3 pricing
//   chip_in      out 12   data bus to the chip
//   chip_valid   in   1   chip output valid
//   chip_out     in  12   chip data (path word or price)
//   chip_resend  in   1   chip request to resend the current path
// ============================================================================
module mc_host_driver #(
  parameter int DAY     = 8,
  parameter int NPATH   = 256,
  parameter int DEPTH   = DAY * NPATH,
  parameter int TIMEOUT = 8191
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] w_i,
  input  logic [11:0] q_i,
  input  logic [11:0] s_i,
  input  logic [11:0] k_i,
  output logic        busy,
  output logic        done,
  output logic [11:0] price_o,
  output logic        err,
  output logic [1:0]  chip_state,
  output logic [11:0] chip_in,
  input  logic        chip_valid,
  input  logic [11:0] chip_out,
  input  logic        chip_resend
);

  localparam int             AW          = $clog2(DEPTH);
  localparam logic [AW-1:0]  c_LAST      = AW'(DEPTH - 1);
  // Clears the word-within-path bits of a buffer address.
  localparam logic [AW-1:0]  c_PATH_MASK = ~AW'(DAY - 1);

  localparam logic [1:0] c_MODE_IDLE  = 2'd0;
  localparam logic [1:0] c_MODE_PARAM = 2'd1;
  localparam logic [1:0] c_MODE_SOBOL = 2'd2;
  localparam logic [1:0] c_MODE_PRICE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PARAM   = 3'd2,
    S_CAPTURE = 3'd3,
    S_PRICE   = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t         r_state;
  logic [1:0]     r_pcnt;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [11:0]    r_w, r_q, r_s, r_k;
  logic           r_busy;
  logic           r_done;
  logic [11:0]    r_price;
  logic [1:0]     r_chip_state;
  logic [11:0]    r_chip_in;

  logic [11:0]    r_buf [DEPTH];

  logic           w_wr_en;
  logic [AW-1:0]  w_rd_addr;
  logic [AW-1:0]  w_rd_next;
  logic [11:0]    w_rd_data;

  // Capture writes and pricing reads never coincide, so one array port
  // serves both. A resend redirects this very read to the path start so the
  // rewound word appears on chip_in right after the request.
  assign w_wr_en   = (r_state == S_CAPTURE) && chip_valid;
  assign w_rd_addr = chip_resend ? (r_rd_ptr & c_PATH_MASK) : r_rd_ptr;
  assign w_rd_next = (w_rd_addr == c_LAST) ? '0 : w_rd_addr + 1'b1;
  assign w_rd_data = r_buf[w_rd_addr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_ptr] <= chip_out;
    end
  end

`ifdef WATCHDOG_EN
  localparam logic [12:0] c_TIMEOUT = 13'(TIMEOUT);
  logic [12:0] r_wd_cnt;
  logic        r_err;
  logic        w_wd_active;

  assign w_wd_active = (r_state == S_CAPTURE) || (r_state == S_PRICE);
  assign err         = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_w          <= '0;
      r_q          <= '0;
      r_s          <= '0;
      r_k          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_price      <= '0;
      r_chip_state <= c_MODE_IDLE;
      r_chip_in    <= '0;
`ifdef WATCHDOG_EN
      r_wd_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_chip_state <= c_MODE_IDLE;
          r_chip_in    <= '0;
          if (start) begin
            r_w          <= w_i;
            r_q          <= q_i;
            r_s          <= s_i;
            r_k          <= k_i;
            r_busy       <= 1'b1;
            r_chip_state <= c_MODE_PARAM;
            r_state      <= S_ARM;
`ifdef WATCHDOG_EN
            r_err        <= 1'b0;
`endif
          end
        end

        S_ARM: begin
          r_chip_in <= r_w;
          r_pcnt    <= '0;
          r_state   <= S_PARAM;
        end

        S_PARAM: begin
          r_pcnt <= r_pcnt + 2'd1;
          case (r_pcnt)
            2'd0:    r_chip_in <= r_q;
            2'd1:    r_chip_in <= r_s;
            2'd2:    r_chip_in <= r_k;
            default: begin
              r_chip_in    <= '0;
              r_chip_state <= c_MODE_SOBOL;
              r_wr_ptr     <= '0;
              r_state      <= S_CAPTURE;
            end
          endcase
        end

        S_CAPTURE: begin
          if (chip_valid) begin
            if (r_wr_ptr == c_LAST) begin
              r_wr_ptr     <= '0;
              r_rd_ptr     <= '0;
              r_chip_state <= c_MODE_PRICE;
              r_state      <= S_PRICE;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end

        S_PRICE: begin
          if (chip_valid) begin
            r_price      <= chip_out;
            r_chip_state <= c_MODE_IDLE;
            r_chip_in    <= '0;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_FIN;
          end else begin
            r_chip_in <= w_rd_data;
            r_rd_ptr  <= w_rd_next;
          end
        end

        S_FIN: begin
          r_chip_state <= c_MODE_IDLE;
          r_chip_in    <= '0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_chip_state <= c_MODE_IDLE;
          r_chip_in    <= '0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase

`ifdef WATCHDOG_EN
      // The counter only runs while waiting on the chip; leaving
      // CAPTURE/PRICE or any valid word restarts it.
      if (w_wd_active && !chip_valid) begin
        if (r_wd_cnt == c_TIMEOUT) begin
          r_wd_cnt     <= '0;
          r_err        <= 1'b1;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_chip_state <= c_MODE_IDLE;
          r_chip_in    <= '0;
          r_state      <= S_FIN;
        end else begin
          r_wd_cnt <= r_wd_cnt + 13'd1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
`endif
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign price_o    = r_price;
  assign chip_state = r_chip_state;
  assign chip_in    = r_chip_in;

endmodule
`default_nettype wire

// File: tb/tb_mc_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_host_driver
// Description : Self-checking bench for mc_host_driver. Expected chip_in
//               words are queued as stimulus is driven and popped as the
//               driver presents them. Build with WATCHDOG_EN to add the
//               watchdog abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_host_driver;

  localparam int DAY     = 8;
  localparam int NPATH   = 256;
  localparam int DEPTH   = DAY * NPATH;
  localparam int TIMEOUT = 8191;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] w_i = '0, q_i = '0, s_i = '0, k_i = '0;
  logic        chip_valid = 1'b0;
  logic [11:0] chip_out = '0;
  logic        chip_resend = 1'b0;
  logic        busy, done, err;
  logic [11:0] price_o, chip_in;
  logic [1:0]  chip_state;

  mc_host_driver #(
    .DAY(DAY), .NPATH(NPATH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .w_i(w_i), .q_i(q_i), .s_i(s_i), .k_i(k_i),
    .busy(busy), .done(done), .price_o(price_o), .err(err),
    .chip_state(chip_state), .chip_in(chip_in),
    .chip_valid(chip_valid), .chip_out(chip_out), .chip_resend(chip_resend)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] q_exp[$];
  logic [11:0] q_rep[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(chip_state), 32'd0);
    check({tag, "_in"},    32'(chip_in),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_price"}, 32'(price_o),    32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
  endtask

  // Accept a job and check the ARM/PARAM sequence; a second start with
  // different parameters plus a stray chip_valid are thrown in mid-sequence.
  task automatic start_job(input logic [11:0] w, q, s, k);
    @(negedge clk);
    start = 1'b1; w_i = w; q_i = q; s_i = s; k_i = k;
    q_exp.delete();
    q_exp.push_back(12'h000);
    q_exp.push_back(w);
    q_exp.push_back(q);
    q_exp.push_back(s);
    q_exp.push_back(k);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("param_state", 32'(chip_state), 32'd1);
      check("param_in", 32'(chip_in), 32'(q_exp.pop_front()));
      if (c == 0) begin
        start = 1'b1; w_i = 12'hFFF; q_i = 12'hEEE; s_i = 12'hDDD; k_i = 12'hCCC;
        chip_valid = 1'b1; chip_out = 12'h777;
      end else begin
        start = 1'b0; chip_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("capture_state", 32'(chip_state), 32'd2);
    check("capture_in", 32'(chip_in), 32'd0);
  endtask

  // Chip model: DEPTH words with values 0..DEPTH-1 and 0-3 idle gaps.
  // abort_at >= 0 pulls reset in the middle of the stream instead.
  task automatic capture(input int abort_at, output bit aborted);
    aborted = 1'b0;
    q_rep.delete();
    for (int i = 0; i < DEPTH; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #2;
        check("async_reset_state", 32'(chip_state), 32'd0);
        @(negedge clk);
        check_reset_vals("midjob_reset");
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (i == DEPTH - 1) check("capture_before_last", 32'(chip_state), 32'd2);
      chip_valid = 1'b1;
      chip_out   = 12'(i);
      q_rep.push_back(12'(i));
      @(negedge clk);
      chip_valid = 1'b0;
    end
    check("price_entry_state", 32'(chip_state), 32'd3);
    // Streaming wraps back to the start of the buffer.
    for (int i = 0; i < 8; i++) q_rep.push_back(12'(i));
  endtask

  task automatic price_phase(input bit do_resend, input logic [11:0] price);
    bit resent;
    resent = 1'b0;
    check("price_first_in", 32'(chip_in), 32'd0);
    @(negedge clk);
    while (q_rep.size() > 0) begin
      logic [11:0] v;
      v = q_rep.pop_front();
      check("replay", 32'(chip_in), 32'(v));
      if (do_resend && !resent && v == 12'h00D) begin
        chip_resend = 1'b1;
        for (int j = 13; j >= 8; j--) q_rep.push_front(12'(j));
        resent = 1'b1;
      end else begin
        chip_resend = 1'b0;
      end
      @(negedge clk);
    end
    check("replay_state", 32'(chip_state), 32'd3);
    // Valid and resend together: the price wins.
    chip_valid = 1'b1; chip_out = price; chip_resend = 1'b1;
    @(negedge clk);
    chip_valid = 1'b0; chip_resend = 1'b0;
    check("fin_done",  32'(done),       32'd1);
    check("fin_state", 32'(chip_state), 32'd0);
    check("fin_busy",  32'(busy),       32'd0);
    check("fin_price", 32'(price_o),    32'(price));
    check("fin_in",    32'(chip_in),    32'd0);
    @(negedge clk);
    check("idle_done",  32'(done),       32'd0);
    check("idle_state", 32'(chip_state), 32'd0);
    chip_valid = 1'b1; chip_out = 12'h111;
    @(negedge clk);
    chip_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_ignored", 32'(price_o), 32'(price));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bit aborted;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full job with a resend and a buffer wrap.
    start_job(12'h123, 12'h045, 12'h800, 12'h7F0);
    capture(-1, aborted);
    check("job1_not_aborted", 32'(aborted), 32'd0);
    price_phase(1'b1, 12'h3A5);

    // Reset mid-capture, then a clean rerun.
    start_job(12'h123, 12'h045, 12'h800, 12'h7F0);
    capture(300, aborted);
    check("job2_aborted", 32'(aborted), 32'd1);
    @(negedge clk);
    start_job(12'h123, 12'h045, 12'h800, 12'h7F0);
    capture(-1, aborted);
    price_phase(1'b0, 12'h5C3);

`ifdef WATCHDOG_EN
    begin
      bit seen;
      seen = 1'b0;
      start_job(12'h001, 12'h002, 12'h003, 12'h004);
      for (int c = 0; c < TIMEOUT + 50 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("wd_done_seen", 32'(seen),       32'd1);
      check("wd_err",       32'(err),        32'd1);
      check("wd_state",     32'(chip_state), 32'd0);
      check("wd_busy",      32'(busy),       32'd0);
      check("wd_price",     32'(price_o),    32'h5C3);
      @(negedge clk);
      check("wd_done_pulse", 32'(done), 32'd0);
      check("wd_err_held",   32'(err),  32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
